// File: rtl/dff_pipe_pkg.sv
// Shared defaults and helpers for the dff_pipe register pipeline.
// Covers the parameter defaults and the occupancy-count width.
package dff_pipe_pkg;

   localparam int          DEF_DW      = 8;
   localparam int          DEF_DEPTH   = 4;
   localparam logic [63:0] DEF_RST_VAL = 64'd0;

   // Width needed to hold an occupancy count of 0..depth.
   function automatic int count_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One valid/data stage of the elastic register pipeline.
// Ready looks forward: the stage can take a word if it is empty or its word is leaving.
module dff_pipe_stage
   import dff_pipe_pkg::*;
#(
   parameter int            DW      = DEF_DW,
   parameter logic [DW-1:0] RST_VAL = '0
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_flush,
   input  logic          i_valid,
   input  logic [DW-1:0] i_d,
   input  logic          i_ready,
   output logic          o_ready,
   output logic          o_valid,
   output logic [DW-1:0] o_q
);

   logic xfer;

   assign o_ready = !o_valid || i_ready;
   assign xfer    = o_ready && i_valid && !i_flush;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         o_valid <= 1'b0;
      else if (i_flush)
         o_valid <= 1'b0;
      else if (o_ready)
         o_valid <= i_valid;
   end

   // Data only moves on a real transfer, so a stalled or flushed stage keeps its word.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         o_q <= RST_VAL;
      else if (xfer)
         o_q <= i_d;
   end

endmodule

// File: rtl/dff_pipe.sv
// Elastic DEPTH-stage register pipeline with valid/ready handshake, flush and occupancy count.
// Empty stages collapse under backpressure so the pipe fills completely before stalling upstream.
module dff_pipe
   import dff_pipe_pkg::*;
#(
   parameter int          DW      = DEF_DW,
   parameter int          DEPTH   = DEF_DEPTH,
   parameter logic [63:0] RST_VAL = DEF_RST_VAL
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_flush,
   input  logic                      i_valid,
   input  logic [DW-1:0]             i_d,
   output logic                      o_ready,
   output logic                      o_valid,
   output logic [DW-1:0]             o_q,
   input  logic                      i_ready,
   output logic [count_w(DEPTH)-1:0] o_count
);

   localparam int            CW       = count_w(DEPTH);
   localparam logic [DW-1:0] RST_DATA = RST_VAL[DW-1:0];

   logic [DEPTH-1:0] v;
   logic [DW-1:0]    d [DEPTH];

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic          rdy;
      logic          next_rdy;
      logic          prev_vld;
      logic [DW-1:0] prev_d;

      if (k == 0) begin : g_head
         assign prev_vld = i_valid;
         assign prev_d   = i_d;
      end else begin : g_body
         assign prev_vld = v[k-1];
         assign prev_d   = d[k-1];
      end

      // The ready chain runs from the output side back to the input side.
      if (k == DEPTH - 1) begin : g_tail
         assign next_rdy = i_ready;
      end else begin : g_link
         assign next_rdy = g_stage[k+1].rdy;
      end

      dff_pipe_stage #(
         .DW      (DW),
         .RST_VAL (RST_DATA)
      ) u_stage (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_flush (i_flush),
         .i_valid (prev_vld),
         .i_d     (prev_d),
         .i_ready (next_rdy),
         .o_ready (rdy),
         .o_valid (v[k]),
         .o_q     (d[k])
      );
   end

   assign o_ready = g_stage[0].rdy;
   assign o_valid = v[DEPTH-1];
   assign o_q     = d[DEPTH-1];

   always_comb begin
      o_count = '0;
      for (int k = 0; k < DEPTH; k++)
         o_count = o_count + CW'(v[k]);
   end

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe (DW=8, DEPTH=3): directed scenarios plus random traffic against a
// word/position-list model of the pipe.
module tb_dff_pipe;

   localparam int DW    = 8;
   localparam int DEPTH = 3;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b0;
   logic          i_flush = 1'b0;
   logic          i_valid = 1'b0;
   logic [DW-1:0] i_d = '0;
   logic          o_ready;
   logic          o_valid;
   logic [DW-1:0] o_q;
   logic          i_ready = 1'b0;
   logic [1:0]    o_count;

   dff_pipe #(.DW(DW), .DEPTH(DEPTH), .RST_VAL(64'd0)) dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_flush),
      .i_valid (i_valid),
      .i_d     (i_d),
      .o_ready (o_ready),
      .o_valid (o_valid),
      .o_q     (o_q),
      .i_ready (i_ready),
      .o_count (o_count)
   );

   always #5 i_clk = ~i_clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: words in flight, oldest first, each with the stage index it sits in.
   logic [7:0] m_dat[$];
   int         m_pos[$];
   logic [7:0] m_last;

   logic [7:0] deliv[$];
   int         deliv_cyc[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic bit model_ready(input bit rdy);
      return rdy || (m_dat.size() < DEPTH);
   endfunction

   task automatic model_reset();
      m_dat.delete();
      m_pos.delete();
      m_last = 8'h00;
   endtask

   task automatic model_edge(input bit vld, input logic [7:0] dat, input bit rdy, input bit fl);
      logic [7:0] nd[$];
      int         np[$];
      int         cap;
      int         p;
      if (fl) begin
         m_dat.delete();
         m_pos.delete();
         return;
      end
      cap = rdy ? DEPTH : DEPTH - 1;
      for (int i = 0; i < m_dat.size(); i++) begin
         p = m_pos[i] + 1;
         if (p > cap) p = cap;
         if (p < DEPTH) begin
            nd.push_back(m_dat[i]);
            np.push_back(p);
            if (p == DEPTH - 1) m_last = m_dat[i];
         end
         cap = p - 1;
      end
      if (vld && cap >= 0) begin
         nd.push_back(dat);
         np.push_back(0);
         if (DEPTH == 1) m_last = dat;
      end
      m_dat = nd;
      m_pos = np;
   endtask

   task automatic check_outputs();
      bit ev;
      ev = (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1);
      check("o_valid", o_valid, ev);
      check("o_q", o_q, m_last);
      check("o_count", o_count, m_dat.size());
      check("o_ready", o_ready, model_ready(i_ready));
      if (o_valid && i_ready) begin
         deliv.push_back(o_q);
         deliv_cyc.push_back(cyc);
      end
   endtask

   // One clock: drive at the falling edge, sample 1 ns later, advance the model at the rising edge.
   task automatic step(input bit vld, input logic [7:0] dat, input bit rdy, input bit fl,
                       output bit acc);
      @(negedge i_clk);
      i_valid = vld;
      i_d     = dat;
      i_ready = rdy;
      i_flush = fl;
      #1;
      check_outputs();
      acc = vld && !fl && model_ready(rdy);
      @(posedge i_clk);
      model_edge(vld, dat, rdy, fl);
      cyc++;
   endtask

   task automatic reset_pulse();
      @(negedge i_clk);
      i_valid = 1'b0;
      i_flush = 1'b0;
      #2;
      i_rst = 1'b1;
      #1;
      check("rst_o_valid", o_valid, 1'b0);
      check("rst_o_q", o_q, 8'h00);
      check("rst_o_count", o_count, 2'd0);
      check("rst_o_ready", o_ready, 1'b1);
      #1;
      i_rst = 1'b0;
      model_reset();
      @(posedge i_clk);
      model_edge(1'b0, 8'h00, i_ready, 1'b0);
      cyc++;
   endtask

   initial begin
      bit acc;
      int idx;
      int c0;

      // Reset with no clock edge needed
      reset_pulse();

      // Streaming at full rate
      deliv.delete(); deliv_cyc.delete();
      c0 = cyc;
      step(1'b1, 8'h11, 1'b1, 1'b0, acc);
      step(1'b1, 8'h22, 1'b1, 1'b0, acc);
      step(1'b1, 8'h33, 1'b1, 1'b0, acc);
      for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
      check("stream_n", deliv.size(), 3);
      check("stream_w0", deliv[0], 8'h11);
      check("stream_w1", deliv[1], 8'h22);
      check("stream_w2", deliv[2], 8'h33);
      check("stream_lat0", deliv_cyc[0], c0 + 3);
      check("stream_lat2", deliv_cyc[2], c0 + 5);

      // Backpressure: source holds each word until it is taken
      deliv.delete(); deliv_cyc.delete();
      idx = 0;
      for (int k = 0; k < 6; k++) begin
         step(idx < 5, 8'hA0 + 8'(idx), 1'b0, 1'b0, acc);
         if (acc) idx++;
      end
      @(negedge i_clk);
      #1;
      check("bp_accepted", idx, 3);
      check("bp_o_ready", o_ready, 1'b0);
      check("bp_o_count", o_count, 2'd3);
      check("bp_o_q", o_q, 8'hA0);
      for (int k = 0; k < 10; k++) begin
         step(idx < 5, 8'hA0 + 8'(idx), 1'b1, 1'b0, acc);
         if (acc) idx++;
      end
      check("bp_n", deliv.size(), 5);
      for (int i = 0; i < 5; i++) check("bp_word", deliv[i], 8'hA0 + i);

      // Full pipe with simultaneous accept and release
      deliv.delete(); deliv_cyc.delete();
      for (int k = 0; k < 3; k++) step(1'b1, 8'hB0 + 8'(k), 1'b0, 1'b0, acc);
      for (int k = 3; k < 7; k++) begin
         step(1'b1, 8'hB0 + 8'(k), 1'b1, 1'b0, acc);
         #1;
         check("pass_count", o_count, 2'd3);
      end
      check("pass_out_n", deliv.size(), 4);
      for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
      check("pass_n", deliv.size(), 7);
      for (int i = 0; i < 7; i++) check("pass_word", deliv[i], 8'hB0 + i);

      // Flush with a word offered in the same cycle
      deliv.delete(); deliv_cyc.delete();
      step(1'b1, 8'hC0, 1'b0, 1'b0, acc);
      step(1'b1, 8'hC1, 1'b0, 1'b0, acc);
      step(1'b1, 8'hC2, 1'b0, 1'b1, acc);
      #1;
      check("flush_count", o_count, 2'd0);
      check("flush_valid", o_valid, 1'b0);
      for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
      check("flush_n", deliv.size(), 0);

      // Reset with two words in flight
      step(1'b1, 8'hD0, 1'b1, 1'b0, acc);
      step(1'b1, 8'hD1, 1'b1, 1'b0, acc);
      reset_pulse();
      deliv.delete(); deliv_cyc.delete();
      c0 = cyc;
      step(1'b1, 8'h5A, 1'b1, 1'b0, acc);
      for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1, 1'b0, acc);
      check("mrst_n", deliv.size(), 1);
      check("mrst_word", deliv[0], 8'h5A);
      check("mrst_lat", deliv_cyc[0], c0 + 3);

      // Random traffic
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 119) == 0) begin
            reset_pulse();
         end else begin
            step($urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 39) == 0, acc);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
